// File: rtl/estagio_ex_pkg.sv
// Shared constants for the execute stage and the ALU it drives.
// Opcodes, widths and the forwarding source encoding live here.
package estagio_ex_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [OP_W-1:0] ALU_LUI = 4'b1011;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_EX,
        FWD_WB
    } fwd_sel_t;

    // A producer matches only when it writes a nonzero register.
    function automatic logic fwd_hit(
        input logic             valid,
        input logic             reg_write,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] src
    );
        return valid && reg_write && (rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/estagio_ex_fwd_mux.sv
// Operand bypass select: EX result first, then WB result, else the
// register-file value. Register 0 always takes the register-file value.
module fwd_mux
    import estagio_ex_pkg::*;
#(
    parameter int DATA_W = estagio_ex_pkg::DATA_W
) (
    input  logic [REG_W-1:0]  src,
    input  logic [DATA_W-1:0] src_val,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] val
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_NONE;
        if (fwd_hit(ex_valid, ex_reg_write, ex_rd, src)) begin
            sel = FWD_EX;
        end else if (fwd_hit(wb_valid, wb_reg_write, wb_rd, src)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        val = src_val;
        case (sel)
            FWD_EX:  val = ex_result;
            FWD_WB:  val = wb_result;
            default: val = src_val;
        endcase
    end

endmodule

// File: rtl/estagio_ex.sv
// Execute stage: forwards operands, drives an external ALU and
// registers its result behind a valid/ready handshake to memory.
module estagio_ex
    import estagio_ex_pkg::*;
#(
    parameter int DATA_W = estagio_ex_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [OP_W-1:0]   id_op,
    input  logic [4:0]        id_shamt,
    input  logic              id_reg_write,
    input  logic              flush,
    output logic [DATA_W-1:0] ula_in1,
    output logic [DATA_W-1:0] ula_in2,
    output logic [OP_W-1:0]   ula_op,
    output logic [4:0]        ula_shamt,
    input  logic [DATA_W-1:0] ula_result,
    input  logic              ula_zero,
    output logic              ex_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ex_result,
    output logic              ex_zero,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_reg_write,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_result
);

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              accept;
    logic              drain;

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs (
        .src          (id_rs),
        .src_val      (id_rs_val),
        .ex_valid     (ex_valid),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .val          (fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W)) u_fwd_rt (
        .src          (id_rt),
        .src_val      (id_rt_val),
        .ex_valid     (ex_valid),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .val          (fwd_rt)
    );

    assign ula_in1   = fwd_rs;
    assign ula_in2   = id_use_imm ? id_imm : fwd_rt;
    assign ula_op    = id_op;
    assign ula_shamt = id_shamt;

    // Flush blocks intake so nothing slips in while the pipe is discarded.
    assign id_ready = !flush && (!ex_valid || mem_ready);
    assign accept   = id_valid && id_ready;
    assign drain    = ex_valid && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_result     <= '0;
            ex_zero       <= 1'b0;
            ex_store_data <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid      <= 1'b1;
            ex_result     <= ula_result;
            ex_zero       <= ula_zero;
            ex_store_data <= fwd_rt;
            ex_rd         <= id_rd;
            ex_reg_write  <= id_reg_write;
        end else if (drain) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_estagio_ex.sv
// Bench for estagio_ex: directed hazard/stall/flush/reset steps,
// then random traffic against a transaction-level reference model.
module tb_estagio_ex;
    import estagio_ex_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic          id_ready;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [W-1:0]  id_rs_val, id_rt_val, id_imm;
    logic          id_use_imm;
    logic [3:0]    id_op;
    logic [4:0]    id_shamt;
    logic          id_reg_write;
    logic          flush;
    logic [W-1:0]  ula_in1, ula_in2;
    logic [3:0]    ula_op;
    logic [4:0]    ula_shamt;
    logic [W-1:0]  ula_result;
    logic          ula_zero;
    logic          ex_valid;
    logic          mem_ready;
    logic [W-1:0]  ex_result;
    logic          ex_zero;
    logic [W-1:0]  ex_store_data;
    logic [4:0]    ex_rd;
    logic          ex_reg_write;
    logic          wb_valid, wb_reg_write;
    logic [4:0]    wb_rd;
    logic [W-1:0]  wb_result;

    int total  = 0;
    int passed = 0;

    logic          m_valid;
    logic [W-1:0]  m_result;
    logic          m_zero;
    logic [W-1:0]  m_store;
    logic [4:0]    m_rd;
    logic          m_rw;
    logic [W-1:0]  held;

    always #5 clk = ~clk;

    estagio_ex #(.DATA_W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_rs_val     (id_rs_val),
        .id_rt_val     (id_rt_val),
        .id_imm        (id_imm),
        .id_use_imm    (id_use_imm),
        .id_op         (id_op),
        .id_shamt      (id_shamt),
        .id_reg_write  (id_reg_write),
        .flush         (flush),
        .ula_in1       (ula_in1),
        .ula_in2       (ula_in2),
        .ula_op        (ula_op),
        .ula_shamt     (ula_shamt),
        .ula_result    (ula_result),
        .ula_zero      (ula_zero),
        .ex_valid      (ex_valid),
        .mem_ready     (mem_ready),
        .ex_result     (ex_result),
        .ex_zero       (ex_zero),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_result     (wb_result)
    );

    function automatic logic [W-1:0] alu_ref(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [3:0]   op
    );
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_LUI: return b << 16;
            default: return '0;
        endcase
    endfunction

    // Environment ALU attached to the stage's ALU port.
    always_comb begin
        ula_result = alu_ref(ula_in1, ula_in2, ula_op);
        ula_zero   = (ula_result == '0);
    end

    function automatic logic [W-1:0] fwd_ref(
        input logic [4:0]   r,
        input logic [W-1:0] v
    );
        if (r == 5'd0) return v;
        if (m_valid && m_rw && m_rd == r) return m_result;
        if (wb_valid && wb_reg_write && wb_rd == r) return wb_result;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_result = '0;
        m_zero   = 1'b0;
        m_store  = '0;
        m_rd     = '0;
        m_rw     = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_valid"}, ex_valid, m_valid);
        chk({tag, "_result"}, ex_result, m_result);
        chk({tag, "_zero"}, ex_zero, m_zero);
        chk({tag, "_store"}, ex_store_data, m_store);
        chk({tag, "_rd"}, ex_rd, m_rd);
        chk({tag, "_rw"}, ex_reg_write, m_rw);
    endtask

    task automatic set_instr(
        input logic [3:0] op, input logic [4:0] rs, input logic [W-1:0] rsv,
        input logic [4:0] rt, input logic [W-1:0] rtv, input logic [4:0] rd,
        input logic rw, input logic ui, input logic [W-1:0] imm
    );
        id_op = op; id_rs = rs; id_rs_val = rsv; id_rt = rt;
        id_rt_val = rtv; id_rd = rd; id_reg_write = rw;
        id_use_imm = ui; id_imm = imm; id_shamt = 5'(rs ^ rt);
    endtask

    // One clock: check combinational side, step model, check registers.
    task automatic cycle(input string tag);
        logic          er;
        logic [W-1:0]  f1, f2, in2, r;
        #1;
        er  = !flush && (!m_valid || mem_ready);
        f1  = fwd_ref(id_rs, id_rs_val);
        f2  = fwd_ref(id_rt, id_rt_val);
        in2 = id_use_imm ? id_imm : f2;
        chk({tag, "_id_ready"}, id_ready, er);
        chk({tag, "_ula_in1"}, ula_in1, f1);
        chk({tag, "_ula_in2"}, ula_in2, in2);
        chk({tag, "_ula_op"}, ula_op, id_op);
        chk({tag, "_ula_shamt"}, ula_shamt, id_shamt);
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
        end else if (id_valid && er) begin
            r        = alu_ref(f1, in2, id_op);
            m_valid  = 1'b1;
            m_result = r;
            m_zero   = (r == '0);
            m_store  = f2;
            m_rd     = id_rd;
            m_rw     = id_reg_write;
        end else if (m_valid && mem_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        logic [3:0] ops [6];
        ops[0] = ALU_AND; ops[1] = ALU_OR;  ops[2] = ALU_ADD;
        ops[3] = ALU_SUB; ops[4] = ALU_SLT; ops[5] = ALU_LUI;

        rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; mem_ready = 1'b1;
        wb_valid = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
        set_instr(ALU_AND, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_regs("reset");
        chk("reset_id_ready", id_ready, 1'b1);
        rst_n = 1'b1;

        // Plain ADD on the first edge after reset release
        set_instr(ALU_ADD, 1, 5, 2, 7, 4, 1, 0, 0);
        id_valid = 1'b1;
        cycle("s1");
        chk("s1_sum", ex_result, 32'd12);
        chk("s1_zf", ex_zero, 1'b0);
        chk("s1_v", ex_valid, 1'b1);

        // EX -> EX forwarding into SUB
        set_instr(ALU_ADD, 5, 4, 6, 6, 3, 1, 0, 0);
        cycle("s2a");
        set_instr(ALU_SUB, 3, 99, 7, 10, 9, 1, 0, 0);
        #1 chk("s2_fwd_ex", ula_in1, 32'd10);
        cycle("s2b");
        chk("s2_sub", ex_result, 32'd0);
        chk("s2_zf", ex_zero, 1'b1);

        // EX beats WB; r0 never forwarded; WB-only forwarding
        set_instr(ALU_ADD, 0, 1, 0, 0, 8, 1, 1, 0);
        cycle("s3a");
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_rd = 8; wb_result = 2;
        set_instr(ALU_OR, 8, 77, 0, 32'h55, 0, 1, 0, 0);
        #1 chk("s3_ex_prio", ula_in1, 32'd1);
        cycle("s3b");
        wb_rd = 0; wb_result = 2;
        set_instr(ALU_ADD, 0, 32'h33, 12, 0, 10, 1, 0, 0);
        #1 chk("s3_r0", ula_in1, 32'h33);
        cycle("s3c");
        wb_rd = 12; wb_result = 32'habc;
        set_instr(ALU_ADD, 12, 0, 0, 0, 11, 1, 1, 1);
        #1 chk("s3_fwd_wb", ula_in1, 32'habc);
        cycle("s3d");
        wb_valid = 1'b0; wb_reg_write = 1'b0;

        // Back-pressure for 3 cycles, then load on release edge
        set_instr(ALU_ADD, 1, 3, 2, 4, 5, 1, 0, 0);
        cycle("s4a");
        held = ex_result;
        mem_ready = 1'b0;
        set_instr(ALU_ADD, 1, 20, 2, 22, 6, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("s4_ready", id_ready, 1'b0);
            cycle("s4_stall");
            chk("s4_hold", ex_result, held);
        end
        mem_ready = 1'b1;
        cycle("s4b");
        chk("s4_load", ex_result, 32'd42);
        chk("s4_rd", ex_rd, 5'd6);

        // Flush overrides acceptance
        flush = 1'b1;
        set_instr(ALU_OR, 1, 1, 2, 2, 7, 1, 0, 0);
        #1 chk("s5_ready", id_ready, 1'b0);
        cycle("s5");
        chk("s5_flush", ex_valid, 1'b0);
        flush = 1'b0;

        // Reset in the middle of a stall
        set_instr(ALU_SUB, 1, 50, 2, 8, 9, 1, 0, 0);
        cycle("s6a");
        mem_ready = 1'b0;
        id_valid = 1'b0;
        cycle("s6b");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("s6_rst");
        @(posedge clk);
        #1;
        check_regs("s6_rst_hold");
        rst_n = 1'b1;
        mem_ready = 1'b1;

        // Random traffic over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            set_instr(ops[$urandom_range(0, 5)],
                      5'($urandom_range(0, 3)), $urandom(),
                      5'($urandom_range(0, 3)), $urandom(),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom());
            if (n % 5 == 0) id_rs_val = id_rt_val;
            id_valid     = 1'($urandom_range(0, 3) != 0);
            mem_ready    = 1'($urandom_range(0, 2) != 0);
            flush        = 1'($urandom_range(0, 15) == 0);
            wb_valid     = 1'($urandom_range(0, 1));
            wb_reg_write = 1'($urandom_range(0, 3) != 0);
            wb_rd        = 5'($urandom_range(0, 3));
            wb_result    = $urandom();
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/estagio_ex.md
ESTAGIO_EX -- requirements
Module: estagio_ex

Interface
REQ-001 Parameter: DATA_W, default 32, datapath width of operands and result.
REQ-002 Ports (one per line: name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  rst_n  in  1  asynchronous reset, active low.
  id_valid  in  1  decode stage offers an instruction.
  id_ready  out  1  stage accepts an instruction this cycle.
  id_rs, id_rt, id_rd  in  5 each  source and destination register numbers.
  id_rs_val, id_rt_val  in  DATA_W each  register-file read values.
  id_imm  in  DATA_W  sign/zero-extended immediate.
  id_use_imm  in  1  operand 2 is id_imm instead of rt.
  id_op  in  4  ALU operation code.
  id_shamt  in  5  shift amount.
  id_reg_write  in  1  instruction writes rd.
  flush  in  1  discard any held result.
  ula_in1, ula_in2  out  DATA_W each  ALU operands.
  ula_op  out  4  ALU operation.
  ula_shamt  out  5  ALU shift amount.
  ula_result  in  DATA_W  ALU result (combinational).
  ula_zero  in  1  ALU zero flag.
  ex_valid  out  1  registered result is valid for the memory stage.
  mem_ready  in  1  memory stage accepts the result.
  ex_result  out  DATA_W  registered ALU result.
  ex_zero  out  1  registered zero flag.
  ex_store_data  out  DATA_W  forwarded rt value, registered.
  ex_rd  out  5  registered destination register.
  ex_reg_write  out  1  registered write enable.
  wb_valid, wb_reg_write  in  1 each  write-back stage state.
  wb_rd  in  5  write-back destination.
  wb_result  in  DATA_W  write-back value.

Function
REQ-003 id_ready SHALL equal (not ex_valid) or mem_ready, combinationally.
REQ-004 An instruction is accepted on a rising edge where id_valid and id_ready are both 1.
REQ-005 The ALU is driven combinationally from the id_* inputs; latency from acceptance to ex_valid is exactly 1 cycle.
REQ-006 Forwarded rs: if ex_valid, ex_reg_write, ex_rd = id_rs and id_rs != 0, use ex_result; else if wb_valid, wb_reg_write, wb_rd = id_rs and id_rs != 0, use wb_result; else use id_rs_val.
REQ-007 Forwarded rt SHALL follow the same rule and priority as REQ-006, with id_rt substituted.
REQ-008 ula_in1 SHALL be forwarded rs; ula_in2 SHALL be id_imm when id_use_imm=1, else forwarded rt; ula_op=id_op; ula_shamt=id_shamt.
REQ-009 On acceptance, the output register SHALL load ula_result, ula_zero, forwarded rt, id_rd and id_reg_write, and SHALL set ex_valid=1.
REQ-010 Under ex_valid=1 and mem_ready=0, every ex_* output SHALL hold unchanged.
REQ-011 If ex_valid=1, mem_ready=1 and there is no acceptance, ex_valid SHALL go to 0 on the next edge.
REQ-012 On simultaneous handoff and acceptance, the new instruction SHALL replace the old one with no bubble.
REQ-013 flush=1 SHALL clear ex_valid on the next edge, overriding acceptance, and id_ready SHALL be held 0 during flush.
REQ-014 Register 0 SHALL never be forwarded; id_rs_val/id_rt_val SHALL pass through unchanged for it.

Reset
REQ-015 With rst_n=0, the stage SHALL asynchronously clear ex_valid, ex_result, ex_zero, ex_store_data, ex_rd and ex_reg_write to 0.
REQ-016 After reset, id_ready SHALL read 1, and the first acceptance is legal on the first edge with rst_n=1.
REQ-017 Reset asserted mid-stall SHALL discard the held result.

Structure
REQ-018 ALU opcode constants (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, LUI 1011) and DATA_W SHALL live in a shared package also used by the ALU.
REQ-019 One sub-module, fwd_mux, SHALL implement the REQ-006 selection and SHALL be instantiated twice (rs, rt); the ALU SHALL stay outside this block.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - ADD, rs_val=5, rt_val=7, no hazards -> ex_result=12, ex_zero=0, ex_valid=1 one cycle later.
  - ADD r3 writes 10, then SUB rs=r3, rt_val=10 -> forwarded 10 from EX, ex_result=0, ex_zero=1.
  - EX and WB both match rs (ex_result=1, wb_result=2) -> EX value 1 used; rs=0 -> id_rs_val used.
  - mem_ready=0 for 3 cycles with id_valid=1 -> id_ready=0 and ex_* stable; release -> next instruction loads on the same edge.
  - flush together with id_valid=1 -> ex_valid=0 next cycle; rst_n low mid-stall -> all ex_* = 0 immediately.
